// File: rtl/left_shifter_seq.sv
// rtl/left_shifter_seq.sv - multi-cycle logical left shifter, STEP bits per clock, valid/ready on both sides
module left_shifter_seq #(
    parameter int N    = 8,
    parameter int STEP = 1,
    localparam int AW  = $clog2(N) + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [N-1:0]  d_in,
    input  logic [AW-1:0] amt,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [N-1:0]  d_out,
    output logic          overflow,
    output logic          busy
);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    localparam logic [AW-1:0] N_W    = AW'(N);
    localparam logic [AW-1:0] STEP_W = AW'(STEP);

    state_t        state;
    logic [N-1:0]  data;
    logic [AW-1:0] remaining;
    logic [AW-1:0] amt_clamped;
    logic [AW-1:0] k;
    logic [N-1:0]  lost_mask;

    // lost_mask selects the top k bits of data, which fall off the MSB this cycle
    always_comb begin
        amt_clamped = (amt > N_W) ? N_W : amt;
        k           = (remaining > STEP_W) ? STEP_W : remaining;
        lost_mask   = ~({N{1'b1}} >> k);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            data      <= '0;
            overflow  <= 1'b0;
            remaining <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        data      <= d_in;
                        overflow  <= 1'b0;
                        remaining <= amt_clamped;
                        state     <= (amt_clamped == '0) ? DONE : SHIFT;
                    end
                end
                SHIFT: begin
                    data      <= data << k;
                    overflow  <= overflow | (|(data & lost_mask));
                    remaining <= remaining - k;
                    if (remaining <= STEP_W) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);
    assign d_out     = data;

endmodule

// File: tb/tb_left_shifter_seq.sv
// tb/tb_left_shifter_seq.sv - self-checking bench for left_shifter_seq with STEP=1 and STEP=3 instances
module tb_left_shifter_seq;

    logic       clk;
    logic       reset;
    logic       in_valid  [2];
    logic       in_ready  [2];
    logic [7:0] d_in      [2];
    logic [3:0] amt       [2];
    logic       out_valid [2];
    logic       out_ready [2];
    logic [7:0] d_out     [2];
    logic       overflow  [2];
    logic       busy      [2];

    int checks = 0;
    int errors = 0;
    int stepv [2] = '{1, 3};

    left_shifter_seq #(.N(8), .STEP(1)) dut1 (
        .clk(clk), .reset(reset),
        .in_valid(in_valid[0]), .in_ready(in_ready[0]), .d_in(d_in[0]), .amt(amt[0]),
        .out_valid(out_valid[0]), .out_ready(out_ready[0]), .d_out(d_out[0]),
        .overflow(overflow[0]), .busy(busy[0])
    );

    left_shifter_seq #(.N(8), .STEP(3)) dut3 (
        .clk(clk), .reset(reset),
        .in_valid(in_valid[1]), .in_ready(in_ready[1]), .d_in(d_in[1]), .amt(amt[1]),
        .out_valid(out_valid[1]), .out_ready(out_ready[1]), .d_out(d_out[1]),
        .overflow(overflow[1]), .busy(busy[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic int clamp8(input logic [3:0] a);
        return (a > 4'd8) ? 8 : int'(a);
    endfunction

    function automatic logic [7:0] exp_data(input logic [7:0] din, input logic [3:0] a);
        logic [15:0] wide;
        wide = {8'h00, din} << clamp8(a);
        return wide[7:0];
    endfunction

    function automatic logic exp_ovf(input logic [7:0] din, input logic [3:0] a);
        if (clamp8(a) == 0) return 1'b0;
        return |(din >> (8 - clamp8(a)));
    endfunction

    function automatic int exp_latency(input logic [3:0] a, input int step);
        if (clamp8(a) == 0) return 1;
        return (clamp8(a) + step - 1) / step + 1;
    endfunction

    // transaction-level model: pending request, edges since accept, expected result
    logic       started = 1'b0;
    logic       pend   [2];
    int         cnt    [2];
    int         lat    [2];
    logic [7:0] ed     [2];
    logic       eo     [2];
    logic [7:0] idle_d [2];

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (reset) begin
                started   <= 1'b1;
                pend[i]   <= 1'b0;
                idle_d[i] <= 8'h00;
            end else if (!pend[i]) begin
                if (in_valid[i]) begin
                    pend[i] <= 1'b1;
                    cnt[i]  <= 1;
                    lat[i]  <= exp_latency(amt[i], stepv[i]);
                    ed[i]   <= exp_data(d_in[i], amt[i]);
                    eo[i]   <= exp_ovf(d_in[i], amt[i]);
                end
            end else if (cnt[i] >= lat[i]) begin
                if (out_ready[i]) begin
                    pend[i]   <= 1'b0;
                    idle_d[i] <= ed[i];
                end
            end else begin
                cnt[i] <= cnt[i] + 1;
            end
        end
    end

    always @(negedge clk) begin
        if (started) begin
            for (int i = 0; i < 2; i++) begin
                chk($sformatf("cmp%0d_in_ready", i), 32'(in_ready[i]), 32'(!pend[i]));
                chk($sformatf("cmp%0d_busy", i), 32'(busy[i]), 32'(pend[i]));
                chk($sformatf("cmp%0d_out_valid", i), 32'(out_valid[i]), 32'(pend[i] && cnt[i] >= lat[i]));
                if (pend[i] && cnt[i] >= lat[i]) begin
                    chk($sformatf("cmp%0d_d_out", i), 32'(d_out[i]), 32'(ed[i]));
                    chk($sformatf("cmp%0d_overflow", i), 32'(overflow[i]), 32'(eo[i]));
                end
                if (!pend[i]) begin
                    chk($sformatf("cmp%0d_d_out_idle", i), 32'(d_out[i]), 32'(idle_d[i]));
                end
            end
        end
    end

    // one request with hand-computed expectations; hold>0 stalls the consumer in DONE
    task automatic req(input int i, input logic [7:0] din, input logic [3:0] a,
                       input logic [7:0] xd, input logic xo, input int xlat, input int hold);
        int l;
        @(negedge clk);
        chk($sformatf("req%0d_in_ready_before", i), 32'(in_ready[i]), 32'd1);
        in_valid[i]  = 1'b1;
        d_in[i]      = din;
        amt[i]       = a;
        out_ready[i] = (hold == 0);
        l = 0;
        do begin
            @(posedge clk);
            l++;
            @(negedge clk);
            in_valid[i] = 1'b0;
        end while (!out_valid[i] && l < 40);
        chk($sformatf("req%0d_latency_%0h_%0d", i, din, a), 32'(l), 32'(xlat));
        chk($sformatf("req%0d_d_out_%0h_%0d", i, din, a), 32'(d_out[i]), 32'(xd));
        chk($sformatf("req%0d_overflow_%0h_%0d", i, din, a), 32'(overflow[i]), 32'(xo));
        chk($sformatf("req%0d_in_ready_done", i), 32'(in_ready[i]), 32'd0);
        for (int h = 0; h < hold; h++) begin
            in_valid[i] = 1'b1;
            d_in[i]     = 8'h55;
            amt[i]      = 4'd1;
            @(posedge clk);
            @(negedge clk);
            chk($sformatf("bp%0d_d_out", i), 32'(d_out[i]), 32'(xd));
            chk($sformatf("bp%0d_overflow", i), 32'(overflow[i]), 32'(xo));
            chk($sformatf("bp%0d_in_ready", i), 32'(in_ready[i]), 32'd0);
            chk($sformatf("bp%0d_out_valid", i), 32'(out_valid[i]), 32'd1);
        end
        in_valid[i]  = 1'b0;
        out_ready[i] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk($sformatf("req%0d_in_ready_after", i), 32'(in_ready[i]), 32'd1);
        chk($sformatf("req%0d_out_valid_after", i), 32'(out_valid[i]), 32'd0);
    endtask

    initial begin
        reset = 1'b1;
        for (int i = 0; i < 2; i++) begin
            in_valid[i]  = 1'b0;
            d_in[i]      = 8'h00;
            amt[i]       = 4'd0;
            out_ready[i] = 1'b1;
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        chk("rst_in_ready", 32'(in_ready[0]), 32'd1);
        chk("rst_out_valid", 32'(out_valid[0]), 32'd0);
        chk("rst_d_out", 32'(d_out[0]), 32'd0);
        chk("rst_busy", 32'(busy[0]), 32'd0);

        req(0, 8'b0000_0110, 4'd3, 8'b0011_0000, 1'b0, 4, 0);
        req(0, 8'b1010_0001, 4'd2, 8'b1000_0100, 1'b1, 3, 0);
        req(0, 8'hA5, 4'd0, 8'hA5, 1'b0, 1, 0);
        req(0, 8'h01, 4'd9, 8'h00, 1'b1, 9, 0);
        req(1, 8'h01, 4'd7, 8'h80, 1'b0, 4, 0);
        req(1, 8'h01, 4'd8, 8'h00, 1'b1, 4, 0);
        req(1, 8'hFF, 4'd15, 8'h00, 1'b1, 4, 0);
        req(1, 8'h96, 4'd2, 8'h58, 1'b1, 2, 0);
        req(0, 8'h0F, 4'd4, 8'hF0, 1'b0, 5, 5);
        req(0, 8'hC3, 4'd1, 8'h86, 1'b1, 2, 0);

        // reset while shifting aborts the request
        @(negedge clk);
        in_valid[0] = 1'b1;
        d_in[0]     = 8'hFF;
        amt[0]      = 4'd5;
        @(posedge clk);
        @(negedge clk);
        in_valid[0] = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("abort_busy_before", 32'(busy[0]), 32'd1);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        chk("abort_in_ready", 32'(in_ready[0]), 32'd1);
        chk("abort_out_valid", 32'(out_valid[0]), 32'd0);
        chk("abort_busy", 32'(busy[0]), 32'd0);
        chk("abort_d_out", 32'(d_out[0]), 32'd0);
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            chk("abort_no_result", 32'(out_valid[0]), 32'd0);
        end

        req(0, 8'h81, 4'd1, 8'h02, 1'b1, 2, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/left_shifter_seq.md
Name: left_shifter_seq

Overview:
- Multi-cycle logical left shifter with valid/ready handshakes on input and output.
- Complements the combinational right shifters in the datapath library. Trades latency for area: it shifts STEP bit positions per clock instead of using a full barrel network.
- Shifts in zeros at the LSB. Flags any 1 bit lost off the MSB end.

Parameters:
- N, 8, data width in bits (N >= 2).
- STEP, 1, maximum bit positions shifted per clock (1 <= STEP <= N).
- AW, $clog2(N)+1, width of the shift-amount port; derived, not overridden.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  request valid.
- in_ready  output  1  block can accept a request.
- d_in  input  N  operand.
- amt  input  AW  shift amount, 0 .. 2^AW-1.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts the result.
- d_out  output  N  shifted result.
- overflow  output  1  at least one 1 bit was shifted out of bit N-1.
- busy  output  1  request in flight (state SHIFT or DONE).

Behaviour:
- Single clock domain. Reset is synchronous and active-high; all state updates occur on the rising edge of clk.
- Reset values: state=IDLE, d_out=0, overflow=0, out_valid=0, busy=0, in_ready=1. Reset has priority over every other event.
- Reset mid-operation (SHIFT or DONE) aborts the request with no result produced. The first post-reset cycle is IDLE with in_ready=1.
- States:
  - IDLE: in_ready=1. Accept on in_valid && in_ready.
  - SHIFT: in_ready=0, busy=1.
  - DONE: out_valid=1, busy=1, in_ready=0.
- in_ready, out_valid and busy decode directly from state.
- Accept in IDLE:
  - Capture data register <= d_in, overflow <= 0.
  - Capture remaining <= min(amt, N), clamped.
  - If the clamped amount is 0, go to DONE; otherwise go to SHIFT.
- SHIFT, each cycle, with k = min(remaining, STEP):
  - data <= data << k, zero fill.
  - overflow <= overflow | (OR of the top k bits of data before the shift).
  - remaining <= remaining - k.
  - If remaining <= STEP, go to DONE; otherwise stay in SHIFT.
- DONE: d_out shows the data register and is stable while out_valid=1 && !out_ready. On out_ready, go to IDLE.
- No overlap: a new request is accepted no earlier than the cycle after the DONE handshake. Minimum spacing between accepts is latency + 1 cycles.
- Latency, counted in clock edges from the accept edge to the edge after which out_valid=1:
  - 1 for amt=0.
  - ceil(min(amt,N)/STEP) + 1 otherwise.
- amt >= N: d_out=0, overflow = |d_in.
- Input signals are ignored outside IDLE. in_valid held high while busy has no effect.
- d_out is updated only on accept and during SHIFT. After the handshake it holds its last value until the next request's shifting.
- overflow is valid only while out_valid=1.

Test Plan:
- Reset, then idle: after reset, in_ready=1, out_valid=0, d_out=0, busy=0. Assert reset during SHIFT of amt=5 -> the next cycle is IDLE, with no out_valid pulse.
- N=8, STEP=1, d_in=8'b0000_0110, amt=3, out_ready=1 -> out_valid rises 4 edges after accept, d_out=8'b0011_0000, overflow=0, in_ready=1 the cycle after the handshake.
- N=8, STEP=1, d_in=8'b1010_0001, amt=2 -> d_out=8'b1000_0100, overflow=1.
- amt=0 with d_in=8'hA5 -> out_valid 1 edge after accept, d_out=8'hA5, overflow=0. amt=9 (clamped) with d_in=8'h01 -> d_out=8'h00, overflow=1, latency 9.
- N=8, STEP=3, d_in=8'h01, amt=7 -> steps 3,3,1, d_out=8'h80, overflow=0, latency 4. Same with amt=8 -> d_out=0, overflow=1, latency 4.
- Backpressure: hold out_ready=0 for 5 cycles in DONE -> d_out and overflow stable, in_ready=0, and a new in_valid is ignored. Release -> IDLE next cycle, and a back-to-back request is then accepted and correct.
